// File: rtl/muldiv_issue.sv
// muldiv_issue: issue/interlock controller for the iterative MUL/DIV unit in EX.
// Fires a one-cycle alugo, stalls EX while the unit iterates, and releases the
// instruction once. DONE parks a completed op that is still held in EX so it
// cannot reissue. A watchdog flags a unit that never drops alubusy.
// Optional build macro: MULDIV_PERF_EN adds the mdops/mdstallcyc perf counters.
module muldiv_issue #(
  parameter int WDOG = 127
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        phi2,
  input  logic        exvalid,
  input  logic        exmd,
  input  logic        exflush,
  input  logic        exhold,
  input  logic        alubusy,
  output logic        alugo,
  output logic        exmdstall,
  output logic        mderr,
  output logic [31:0] mdops,
  output logic [31:0] mdstallcyc
);
  localparam int WW = $clog2(WDOG + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t        state, state_nxt;
  logic [WW-1:0] wdcnt;
  logic          req;
  logic          wd_clr, wd_inc;

  assign req = exvalid & exmd & ~exflush;

  // State register; advances only on phi2, reset wins regardless of phi2.
  always_ff @(posedge clk) begin
    if (rst)       state <= IDLE;
    else if (phi2) state <= state_nxt;
  end

  // Next-state and handshake decode.
  always_comb begin
    state_nxt = state;
    alugo     = 1'b0;
    exmdstall = 1'b0;
    wd_clr    = 1'b0;
    wd_inc    = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          // A unit still busy from before a reset must drain before reissue.
          exmdstall = 1'b1;
          if (!alubusy) begin
            alugo     = 1'b1;
            wd_clr    = 1'b1;
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        // The unit cannot be aborted, so a flush here just rides to completion.
        exmdstall = alubusy;
        if (alubusy) wd_inc = 1'b1;
        else         state_nxt = exhold ? DONE : IDLE;
      end
      DONE: begin
        if (!exhold) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Saturating RUN watchdog with a sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdcnt <= '0;
      mderr <= 1'b0;
    end else if (phi2) begin
      if (wd_clr) begin
        wdcnt <= '0;
      end else if (wd_inc && wdcnt != WW'(WDOG)) begin
        wdcnt <= wdcnt + 1'b1;
        if (wdcnt == WW'(WDOG - 1)) mderr <= 1'b1;
      end
    end
  end

`ifdef MULDIV_PERF_EN
  logic [31:0] ops_q, stall_q;

  // Issue and stall-cycle perf counters, wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      ops_q   <= '0;
      stall_q <= '0;
    end else if (phi2) begin
      if (alugo)     ops_q   <= ops_q + 32'd1;
      if (exmdstall) stall_q <= stall_q + 32'd1;
    end
  end

  assign mdops      = ops_q;
  assign mdstallcyc = stall_q;
`else
  assign mdops      = '0;
  assign mdstallcyc = '0;
`endif

endmodule
